cart_header_scan: RTL and testbench



---
 rtl/gb_cart_pkg.sv | 32 +++
 rtl/cart_logo_probe.sv | 44 ++++
 rtl/cart_header_scan.sv | 210 +++++++++++++++++++++
 tb/tb_cart_header_scan.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cart_pkg.sv
// Shared definitions for the cartridge header snooping logic.
//   - Header byte offsets within bank 0 (12-bit offsets, bank-0 addresses).
//   - Scanner FSM state type and the captured-header record.
package gb_cart_pkg;

    localparam logic [11:0] HDR_CGB   = 12'h143;
    localparam logic [11:0] HDR_SGB   = 12'h146;
    localparam logic [11:0] HDR_TYPE  = 12'h147;
    localparam logic [11:0] HDR_ROM   = 12'h148;
    localparam logic [11:0] HDR_RAM   = 12'h149;
    localparam logic [11:0] HDR_LIC   = 12'h14B;
    localparam logic [11:0] CSUM_LO   = 12'h134;
    localparam logic [11:0] CSUM_HI   = 12'h14C;
    localparam logic [11:0] CSUM_REF  = 12'h14D;
    localparam logic [11:0] LOGO_BASE = 12'h104;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] cgb;
        logic [7:0] sgb;
        logic [7:0] typ;
        logic [7:0] rom;
        logic [7:0] ram;
        logic [7:0] lic;
    } hdr_t;

endpackage

// File: rtl/cart_logo_probe.sv
// One logo probe: tracks in-order, matching logo words seen in its bank.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart tracking (new download)
//   hit_i         : a logo-window word for this probe's bank is being written
//   idx_i         : word index of that write inside the logo window
//   eq_i          : the written word equals the stored bank-0 logo word
//   match_o       : every logo word arrived in order and matched
module cart_logo_probe #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             hit_i,
    input  logic [SEL_W-1:0] idx_i,
    input  logic             eq_i,
    output logic             match_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             fail_q;

    // Once complete, any further hit has an index past the end and fails.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            fail_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            fail_q <= 1'b0;
        end else if (hit_i) begin
            if ((CNT_W'(idx_i) == cnt_q) && eq_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                fail_q <= 1'b1;
            end
        end
    end

    assign match_o = ~fail_q & (cnt_q == CNT_W'(ENTRIES));

endmodule

// File: rtl/cart_header_scan.sv
// Snoops the ROM download stream, captures cartridge header fields,
// verifies the header checksum, detects multicart logo copies, and paces
// the download with a wait/write handshake.
//   clk_sys, reset_n       : clock, asynchronous active-low reset
//   ce                     : pacing enable
//   dl_active/dl_wr/dl_addr/dl_data : download port (byte address, LE words)
//   dl_wait, dn_write      : stall to source, SDRAM write slot
//   cart_ready             : a word has been committed since download start
//   hdr_valid              : header outputs are final
//   mbc_type..old_licensee : captured header bytes
//   hdr_csum_ok            : computed checksum equals byte 0x14D
//   probe_match            : bit k-1 set when probe bank k carries the logo
module cart_header_scan
    import gb_cart_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned NUM_PROBES  = 3,
    parameter int unsigned PROBE_SHIFT = 18,
    parameter int unsigned LOGO_BYTES  = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  dl_active,
    input  logic                  dl_wr,
    input  logic [ADDR_W-1:0]     dl_addr,
    input  logic [DATA_W-1:0]     dl_data,
    output logic                  dl_wait,
    output logic                  dn_write,
    output logic                  cart_ready,
    output logic                  hdr_valid,
    output logic [7:0]            mbc_type,
    output logic [7:0]            rom_size,
    output logic [7:0]            ram_size,
    output logic [7:0]            cgb_flag,
    output logic [7:0]            sgb_flag,
    output logic [7:0]            old_licensee,
    output logic                  hdr_csum_ok,
    output logic [NUM_PROBES-1:0] probe_match
);

    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned BSH      = (BYTES == 2) ? 1 : 0;
    localparam int unsigned LOGO_ENT = LOGO_BYTES / BYTES;
    localparam int unsigned SEL_W    = (LOGO_ENT > 1) ? $clog2(LOGO_ENT) : 1;
    localparam int unsigned CNT_W    = $clog2(LOGO_ENT + 1);
    localparam logic [11:0] LOGO_END = LOGO_BASE + 12'(LOGO_BYTES);

    state_e state_q, state_d;
    logic   act_q;
    logic   rise, fall, enter_scan, snoop, bank0, logo_win;

    logic [11:0]      off, logo_off, lane_addr;
    logic [7:0]       lane_byte;
    logic [SEL_W-1:0] logo_sel;
    logic             logo_eq;

    hdr_t       hdr_q, hdr_d;
    logic [7:0] csum_q, csum_d;
    logic       csum_ok_q, csum_ok_d;
    logic       dl_wait_q, dn_write_q, cart_ready_q;

    logic [DATA_W-1:0] logo_q [LOGO_ENT];

    assign rise = dl_active & ~act_q;
    assign fall = ~dl_active & act_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = SCAN;
            SCAN:    if (fall) state_d = DONE;
            DONE:    if (rise) state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= dl_active;
        end
    end

    assign enter_scan = (state_d == SCAN) && (state_q != SCAN);
    assign snoop      = dl_wr && (state_q == SCAN);
    assign off        = dl_addr[11:0];
    assign bank0      = (dl_addr[ADDR_W-1:12] == '0);
    assign logo_win   = (off >= LOGO_BASE) && (off < LOGO_END);
    assign logo_off   = off - LOGO_BASE;
    assign logo_sel   = SEL_W'(logo_off >> BSH);
    assign logo_eq    = (dl_data == logo_q[logo_sel]);

    // Lanes are walked low byte first so that with 16-bit words the checksum
    // byte 0x14D is compared against an accumulator already including 0x14C.
    always_comb begin
        hdr_d     = hdr_q;
        csum_d    = csum_q;
        csum_ok_d = csum_ok_q;
        lane_addr = '0;
        lane_byte = '0;
        if (enter_scan) begin
            hdr_d     = '0;
            csum_d    = '0;
            csum_ok_d = 1'b0;
        end else if (snoop && bank0) begin
            for (int unsigned l = 0; l < BYTES; l++) begin
                lane_addr = off + 12'(l);
                lane_byte = dl_data[8*l +: 8];
                case (lane_addr)
                    HDR_CGB:  hdr_d.cgb = lane_byte;
                    HDR_SGB:  hdr_d.sgb = lane_byte;
                    HDR_TYPE: hdr_d.typ = lane_byte;
                    HDR_ROM:  hdr_d.rom = lane_byte;
                    HDR_RAM:  hdr_d.ram = lane_byte;
                    HDR_LIC:  hdr_d.lic = lane_byte;
                    default:  ;
                endcase
                if ((lane_addr >= CSUM_LO) && (lane_addr <= CSUM_HI)) begin
                    csum_d = csum_d - lane_byte - 8'd1;
                end
                if (lane_addr == CSUM_REF) begin
                    csum_ok_d = (csum_d == lane_byte);
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q     <= '0;
            csum_q    <= '0;
            csum_ok_q <= 1'b0;
        end else begin
            hdr_q     <= hdr_d;
            csum_q    <= csum_d;
            csum_ok_q <= csum_ok_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < LOGO_ENT; i++) logo_q[i] <= '0;
        end else if (enter_scan) begin
            for (int unsigned i = 0; i < LOGO_ENT; i++) logo_q[i] <= '0;
        end else if (snoop && bank0 && logo_win) begin
            logo_q[logo_sel] <= dl_data;
        end
    end

    for (genvar k = 1; k <= NUM_PROBES; k++) begin : g_probe
        logic hit;
        assign hit = snoop && logo_win
                  && (dl_addr[ADDR_W-1:PROBE_SHIFT] == (ADDR_W-PROBE_SHIFT)'(k))
                  && (dl_addr[PROBE_SHIFT-1:12] == '0);

        cart_logo_probe #(
            .ENTRIES (LOGO_ENT),
            .SEL_W   (SEL_W),
            .CNT_W   (CNT_W)
        ) u_probe (
            .clk_i   (clk_sys),
            .rst_ni  (reset_n),
            .clear_i (enter_scan),
            .hit_i   (hit),
            .idx_i   (logo_sel),
            .eq_i    (logo_eq),
            .match_o (probe_match[k-1])
        );
    end

    // dn_write spans one ce period: set at the first ce after the wait is
    // raised, dropped (with the wait) at the following ce.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_wait_q    <= 1'b0;
            dn_write_q   <= 1'b0;
            cart_ready_q <= 1'b0;
        end else begin
            if (ce) begin
                if (dn_write_q) begin
                    dn_write_q   <= 1'b0;
                    dl_wait_q    <= 1'b0;
                    cart_ready_q <= 1'b1;
                end else begin
                    dn_write_q <= dl_wait_q;
                end
            end
            if (dl_wr) dl_wait_q <= 1'b1;
            if (enter_scan) cart_ready_q <= 1'b0;
        end
    end

    assign dl_wait      = dl_wait_q;
    assign dn_write     = dn_write_q;
    assign cart_ready   = cart_ready_q;
    assign hdr_valid    = (state_q == DONE);
    assign mbc_type     = hdr_q.typ;
    assign rom_size     = hdr_q.rom;
    assign ram_size     = hdr_q.ram;
    assign cgb_flag     = hdr_q.cgb;
    assign sgb_flag     = hdr_q.sgb;
    assign old_licensee = hdr_q.lic;
    assign hdr_csum_ok  = csum_ok_q;

endmodule

// File: tb/tb_cart_header_scan.sv
module tb_cart_header_scan;

    localparam int DW = 16;
    localparam int AW = 25;
    localparam int NP = 3;
    localparam int PS = 18;
    localparam int LB = 16;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ce;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [DW-1:0] dl_data;
    logic          dl_wait, dn_write, cart_ready, hdr_valid, hdr_csum_ok;
    logic [7:0]    mbc_type, rom_size, ram_size, cgb_flag, sgb_flag, old_licensee;
    logic [NP-1:0] probe_match;

    always #5 clk_sys = ~clk_sys;

    logic [1:0] ce_cnt = 2'd0;
    always @(posedge clk_sys) ce_cnt <= ce_cnt + 2'd1;
    assign ce = (ce_cnt == 2'd3);

    cart_header_scan #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .NUM_PROBES  (NP),
        .PROBE_SHIFT (PS),
        .LOGO_BYTES  (LB)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ce           (ce),
        .dl_active    (dl_active),
        .dl_wr        (dl_wr),
        .dl_addr      (dl_addr),
        .dl_data      (dl_data),
        .dl_wait      (dl_wait),
        .dn_write     (dn_write),
        .cart_ready   (cart_ready),
        .hdr_valid    (hdr_valid),
        .mbc_type     (mbc_type),
        .rom_size     (rom_size),
        .ram_size     (ram_size),
        .cgb_flag     (cgb_flag),
        .sgb_flag     (sgb_flag),
        .old_licensee (old_licensee),
        .hdr_csum_ok  (hdr_csum_ok),
        .probe_match  (probe_match)
    );

    int n_checks = 0;
    int n_errors = 0;
    int words_sent = 0;
    int dn_pulses = 0;
    logic dn_prev = 1'b0;
    logic proto_bad = 1'b0;

    // Header image bytes 0x100..0x14F
    logic [7:0] hdr [0:79];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (dn_write && !dn_prev) dn_pulses++;
        dn_prev = dn_write;
        if (dl_wr && dl_wait) proto_bad = 1'b1;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (dl_wait && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("wait_timeout", 1, 0);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle();
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        tick();
        dl_wr   = 1'b0;
        words_sent++;
    endtask

    task automatic start_dl();
        dl_active = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic end_dl();
        wait_idle();
        dl_active = 1'b0;
        tick(); tick(); tick();
    endtask

    // nb = number of 256 KB banks in the image; cmask bit k corrupts bank k's logo
    task automatic run_trial(input int nb, input logic [3:0] cmask, input logic bad);
        logic [7:0]    x;
        logic [NP-1:0] exp_m;
        logic [DW-1:0] d;
        int            base_p, base_w, cw;
        for (int i = 0; i < 80; i++) hdr[i] = 8'($urandom);
        x = 8'h00;
        for (int a = 'h34; a <= 'h4C; a++) x = x - hdr[a] - 8'd1;
        hdr['h4D] = bad ? (x ^ 8'($urandom_range(1, 255))) : x;

        start_dl();
        check("entry_hdr_valid", hdr_valid, 0);
        check("entry_ready", cart_ready, 0);
        check("entry_probe", probe_match, 0);
        check("entry_csum", hdr_csum_ok, 0);
        base_p = dn_pulses;
        base_w = words_sent;

        for (int w = 0; w < 80; w += 2) send_word(AW'('h100 + w), {hdr[w+1], hdr[w]});
        // outside bank-0 first 4 KB: must not alias onto header fields
        send_word(AW'('h2146), 16'(~{hdr['h47], hdr['h46]}));

        exp_m = '0;
        for (int k = 1; k < nb && k <= NP; k++) begin
            cw = 'h104 + $urandom_range(0, LB - 1);
            for (int w = 'h104; w < 'h104 + LB; w += 2) begin
                d = {hdr[w+1-'h100], hdr[w-'h100]};
                if (cmask[k] && (cw == w))     d[7:0]  = d[7:0] ^ 8'h5A;
                if (cmask[k] && (cw == w + 1)) d[15:8] = d[15:8] ^ 8'h5A;
                send_word(AW'((k << PS) + w), d);
            end
            // same logo offset but not in the probe's first 4 KB: ignored
            send_word(AW'((k << PS) + 'h1104), 16'hDEAD);
            exp_m[k-1] = !cmask[k];
        end
        end_dl();

        check("hdr_valid", hdr_valid, 1);
        check("mbc_type", mbc_type, hdr['h47]);
        check("rom_size", rom_size, hdr['h48]);
        check("ram_size", ram_size, hdr['h49]);
        check("cgb_flag", cgb_flag, hdr['h43]);
        check("sgb_flag", sgb_flag, hdr['h46]);
        check("old_lic", old_licensee, hdr['h4B]);
        check("csum_ok", hdr_csum_ok, !bad);
        check("probe_match", probe_match, exp_m);
        check("cart_ready", cart_ready, 1);
        check("dn_pulses", dn_pulses - base_p, words_sent - base_w);
    endtask

    task automatic hs_test();
        int   seen;
        logic s;
        int   base_p;
        start_dl();
        check("hs_ready0", cart_ready, 0);
        base_p = dn_pulses;
        dl_addr = AW'('h100);
        dl_data = 16'h0000;
        dl_wr   = 1'b1;
        @(negedge clk_sys);
        @(posedge clk_sys);
        #1;
        dl_wr = 1'b0;
        check("hs_wait_set", dl_wait, 1);
        check("hs_dn_idle", dn_write, 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_sys);
            s = ce;
            @(posedge clk_sys);
            #1;
            if (s) seen++;
            check("hs_dn", dn_write, (seen == 1));
            check("hs_wait", dl_wait, (seen < 2));
            check("hs_ready", cart_ready, (seen >= 2));
        end
        check("hs_one_pulse", dn_pulses - base_p, 1);
        end_dl();
    endtask

    initial begin
        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        tick();
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_wait", dl_wait, 0);
        check("rst_dn", dn_write, 0);
        check("rst_ready", cart_ready, 0);
        check("rst_probe", probe_match, 0);
        check("rst_csum", hdr_csum_ok, 0);

        hs_test();

        run_trial(1, 4'b0000, 1'b0);   // 32 KB, good checksum
        run_trial(1, 4'b0000, 1'b1);   // bad checksum
        run_trial(4, 4'b0000, 1'b0);   // 1 MB, all logo copies
        run_trial(4, 4'b0100, 1'b0);   // bank 2 logo altered
        run_trial(2, 4'b0000, 1'b0);   // 512 KB
        for (int t = 0; t < 6; t++)
            run_trial($urandom_range(1, 4), 4'($urandom_range(0, 15)) & 4'b1110, 1'($urandom_range(0, 1)));

        // asynchronous reset in the middle of a scan
        start_dl();
        for (int w = 0; w < 'h46; w += 2) send_word(AW'('h100 + w), 16'($urandom));
        send_word(AW'('h146), 16'h0300);
        check("mid_mbc", mbc_type, 8'h03);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_mbc", mbc_type, 0);
        check("arst_wait", dl_wait, 0);
        check("arst_dn", dn_write, 0);
        check("arst_ready", cart_ready, 0);
        check("arst_valid", hdr_valid, 0);
        check("arst_sgb", sgb_flag, 0);
        dl_active = 1'b0;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        tick(); tick();
        run_trial(4, 4'b0010, 1'b0);

        check("no_wr_during_wait", proto_bad, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
